// File: rtl/stepper_multi_drv.sv
// N-channel unipolar stepper driver sharing one programmable step-rate tick.
// Optional soft position limits and limit_hit outputs: define STEPPER_LIMIT_EN.
module stepper_multi_drv #(
  parameter int                       NCH     = 2,
  parameter int                       DIV_W   = 17,
  parameter int                       POS_W   = 16,
  parameter logic signed [POS_W-1:0]  POS_MAX = 16'sh7FFF,
  parameter logic signed [POS_W-1:0]  POS_MIN = 16'sh8000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DIV_W-1:0]        period,
  input  logic [2*NCH-1:0]        dir,
  input  logic [NCH-1:0]          half_step,
  output logic [4*NCH-1:0]        phase,
  output logic [POS_W*NCH-1:0]    pos,
  output logic [NCH-1:0]          step_pulse
`ifdef STEPPER_LIMIT_EN
  ,
  output logic [NCH-1:0]          limit_hit
`endif
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] term_cnt;
  logic             tick_q, tick_d;

  // Periods below 2 clamp to 2 so the tick never sticks high.
  always_comb begin
    term_cnt = (period < DIV_W'(2)) ? DIV_W'(1) : (period - DIV_W'(1));
    if (cnt_q >= term_cnt) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + DIV_W'(1);
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  function automatic logic [3:0] phase_lut(input logic [2:0] i);
    case (i)
      3'd0:    phase_lut = 4'b0111;
      3'd1:    phase_lut = 4'b0011;
      3'd2:    phase_lut = 4'b1011;
      3'd3:    phase_lut = 4'b1001;
      3'd4:    phase_lut = 4'b1101;
      3'd5:    phase_lut = 4'b1100;
      3'd6:    phase_lut = 4'b1110;
      default: phase_lut = 4'b0110;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : ch_g
      logic [1:0]              dir_ch;
      logic [2:0]              idx_q, idx_d, step_sz;
      logic signed [POS_W-1:0] pos_q, pos_d;
      logic [3:0]              ph_q, ph_d;
      logic                    sp_q, sp_d;
      logic                    fwd, rev;

      assign dir_ch = dir[2*gi +: 2];

      always_comb begin
        // Full-step from an even (single-coil) index moves 1 to realign onto a two-coil state.
        step_sz = (half_step[gi] || !idx_q[0]) ? 3'd1 : 3'd2;
        fwd     = tick_q && (dir_ch == 2'b01);
        rev     = tick_q && (dir_ch == 2'b10);
`ifdef STEPPER_LIMIT_EN
        fwd     = fwd && (pos_q != POS_MAX);
        rev     = rev && (pos_q != POS_MIN);
`endif
        idx_d   = idx_q;
        pos_d   = pos_q;
        sp_d    = 1'b0;
        if (fwd) begin
          idx_d = idx_q + step_sz;
          pos_d = pos_q + POS_W'(1);
          sp_d  = 1'b1;
        end else if (rev) begin
          idx_d = idx_q - step_sz;
          pos_d = pos_q - POS_W'(1);
          sp_d  = 1'b1;
        end
        ph_d = (dir_ch == 2'b11) ? 4'b1111 : phase_lut(idx_d);
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          idx_q <= 3'd0;
          pos_q <= '0;
          ph_q  <= 4'b1111;
          sp_q  <= 1'b0;
        end else begin
          idx_q <= idx_d;
          pos_q <= pos_d;
          ph_q  <= ph_d;
          sp_q  <= sp_d;
        end
      end

      assign phase[4*gi +: 4]         = ph_q;
      assign pos[POS_W*gi +: POS_W]   = pos_q;
      assign step_pulse[gi]           = sp_q;

`ifdef STEPPER_LIMIT_EN
      logic lh_q, lh_d;

      assign lh_d = (pos_d == POS_MAX) || (pos_d == POS_MIN);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          lh_q <= 1'b0;
        end else begin
          lh_q <= lh_d;
        end
      end

      assign limit_hit[gi] = lh_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_stepper_multi_drv.sv
// Self-checking bench for stepper_multi_drv: cycle scoreboard from a behavioural model,
// a table of command segments with fixed expected end states, and hand-built corner cases.
module tb_stepper_multi_drv;

  localparam int NCH   = 2;
  localparam int DIV_W = 17;
  localparam int POS_W = 8;

  logic                 clk;
  logic                 rst_n;
  logic [DIV_W-1:0]     per_s;
  logic [2*NCH-1:0]     dir_s;
  logic [NCH-1:0]       hs_s;
  logic [4*NCH-1:0]     phase_o;
  logic [POS_W*NCH-1:0] pos_o;
  logic [NCH-1:0]       sp_o;
  logic [NCH-1:0]       lh_o;

  stepper_multi_drv #(
    .NCH(NCH), .DIV_W(DIV_W), .POS_W(POS_W),
    .POS_MAX(8'sh7F), .POS_MIN(8'sh80)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .period(per_s),
    .dir(dir_s),
    .half_step(hs_s),
    .phase(phase_o),
    .pos(pos_o),
    .step_pulse(sp_o)
`ifdef STEPPER_LIMIT_EN
    ,
    .limit_hit(lh_o)
`endif
  );

`ifndef STEPPER_LIMIT_EN
  assign lh_o = '0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model and scoreboard
  typedef struct {
    logic [4*NCH-1:0]     phase;
    logic [POS_W*NCH-1:0] pos;
    logic [NCH-1:0]       sp;
    logic [NCH-1:0]       lh;
  } exp_t;

  exp_t sb_q[$];
  logic [3:0] ptab [8] = '{4'b0111, 4'b0011, 4'b1011, 4'b1001,
                           4'b1101, 4'b1100, 4'b1110, 4'b0110};
  int                      m_cnt = 0;
  bit                      m_tick = 0;
  bit                      m_stepped = 0;
  int                      m_idx [NCH];
  logic signed [POS_W-1:0] m_pos [NCH];
  logic [3:0]              m_ph  [NCH];
  bit                      m_sp  [NCH];
  bit                      m_lh  [NCH];
  bit                      chk_en = 0;

  task automatic push_exp();
    exp_t e;
    for (int c = 0; c < NCH; c++) begin
      e.phase[4*c +: 4]         = m_ph[c];
      e.pos[POS_W*c +: POS_W]   = m_pos[c];
      e.sp[c]                   = m_sp[c];
      e.lh[c]                   = m_lh[c];
    end
    sb_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = 0; m_tick = 0; m_stepped = 0;
        for (int c = 0; c < NCH; c++) begin
          m_idx[c] = 0; m_pos[c] = '0; m_ph[c] = 4'b1111; m_sp[c] = 0; m_lh[c] = 0;
        end
        sb_q.delete();
        push_exp();
      end else begin
        int eff;
        m_stepped = m_tick;
        for (int c = 0; c < NCH; c++) begin
          logic [1:0] d;
          int s;
          bit ok;
          d = dir_s[2*c +: 2];
          m_sp[c] = 0;
          ok = 1;
`ifdef STEPPER_LIMIT_EN
          if (d == 2'b01 && m_pos[c] == 8'sh7F) ok = 0;
          if (d == 2'b10 && m_pos[c] == 8'sh80) ok = 0;
`endif
          if (m_tick && ok && (d == 2'b01 || d == 2'b10)) begin
            s = (hs_s[c] || (m_idx[c] % 2 == 0)) ? 1 : 2;
            if (d == 2'b01) begin
              m_idx[c] = (m_idx[c] + s) % 8;
              m_pos[c] = m_pos[c] + 8'sd1;
            end else begin
              m_idx[c] = (m_idx[c] + 8 - s) % 8;
              m_pos[c] = m_pos[c] - 8'sd1;
            end
            m_sp[c] = 1;
          end
          m_ph[c] = (d == 2'b11) ? 4'b1111 : ptab[m_idx[c]];
`ifdef STEPPER_LIMIT_EN
          m_lh[c] = (m_pos[c] == 8'sh7F) || (m_pos[c] == 8'sh80);
`endif
        end
        eff = (per_s < 2) ? 2 : int'(per_s);
        if (m_cnt >= eff - 1) begin
          m_cnt = 0; m_tick = 1;
        end else begin
          m_cnt++; m_tick = 0;
        end
        push_exp();
      end
    end
  end

  // Output checker: compares against the newest model state each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
          while (sb_q.size() > 1) e = sb_q.pop_front();
          e = sb_q.pop_front();
          check("sb_phase", 32'(phase_o), 32'(e.phase));
          check("sb_pos",   32'(pos_o),   32'(e.pos));
          check("sb_step",  32'(sp_o),    32'(e.sp));
          check("sb_limit", 32'(lh_o),    32'(e.lh));
        end
      end
    end
  end

  task automatic wait_ticks(input string nm, input int n);
    int k = 0;
    int c = 0;
    while (k < n && c < 2000) begin
      @(negedge clk);
      c++;
      if (m_stepped) k++;
    end
    check({nm, "_ticks"}, 32'(k), 32'(n));
  endtask

  task automatic wait_pulse(input string nm, input int budget);
    int  c = 0;
    bit  seen = 0;
    while (c < budget && !seen) begin
      @(negedge clk);
      c++;
      if (sp_o[0]) seen = 1;
    end
    check(nm, 32'(seen), 32'd1);
  endtask

  typedef struct {
    logic [3:0]  dir;
    logic [1:0]  hs;
    logic [16:0] per;
    int          nticks;
    logic [7:0]  exp_phase;
    logic [15:0] exp_pos;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int   cyc;
    int   bad;
    bit   found;
    logic [5:0] hist;

    vecs[0] = '{4'b0001, 2'b11, 17'd4, 8, 8'h77, 16'h0008}; // ch0 half fwd full cycle
    vecs[1] = '{4'b0010, 2'b00, 17'd4, 5, 8'h76, 16'h0003}; // ch0 full rev from even idx
    vecs[2] = '{4'b0111, 2'b10, 17'd4, 3, 8'h9F, 16'h0303}; // ch0 release, ch1 half fwd
    vecs[3] = '{4'b1001, 2'b00, 17'd4, 2, 8'h69, 16'h0105}; // both full from odd idx
    vecs[4] = '{4'b0000, 2'b00, 17'd4, 3, 8'h69, 16'h0105}; // hold
    vecs[5] = '{4'b0001, 2'b01, 17'd1, 4, 8'h66, 16'h0109}; // period 1 treated as 2

    rst_n = 1'b1; dir_s = '0; hs_s = '0; per_s = 17'd4;
    #1 rst_n = 1'b0;
    chk_en = 1;
    repeat (2) @(negedge clk);
    check("reset_phase", 32'(phase_o), 32'h0000_00FF);
    check("reset_pos",   32'(pos_o),   32'h0);
    check("reset_step",  32'(sp_o),    32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("release_phase", 32'(phase_o), 32'h0000_0077);

    for (int v = 0; v < 6; v++) begin
      dir_s = vecs[v].dir; hs_s = vecs[v].hs; per_s = vecs[v].per;
      wait_ticks($sformatf("vec%0d", v), vecs[v].nticks);
      check($sformatf("vec%0d_phase", v), 32'(phase_o), 32'(vecs[v].exp_phase));
      check($sformatf("vec%0d_pos", v),   32'(pos_o),   32'(vecs[v].exp_pos));
    end

    // Step spacing at period 10, then a period drop below the running count
    dir_s = 4'b0001; hs_s = 2'b01; per_s = 17'd10;
    wait_pulse("p10_first", 40);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sp_o[0] && cyc < 30);
    check("p10_interval", 32'(cyc), 32'd10);
    found = 0;
    cyc = 0;
    while (!found && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (m_cnt == 7) found = 1;
    end
    check("cnt7_found", 32'(found), 32'd1);
    per_s = 17'd2;
    hist = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hist = {hist[4:0], sp_o[0]};
    end
    check("per_drop_pulses", 32'(hist), 32'(6'b010101));

    // Asynchronous reset while ch0 is stepping
    @(negedge clk);
    #1 rst_n = 1'b0; dir_s = '0; hs_s = '0;
    #1;
    check("async_rst_phase", 32'(phase_o), 32'h0000_00FF);
    check("async_rst_pos",   32'(pos_o),   32'h0);
    check("async_rst_step",  32'(sp_o),    32'h0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_phase", 32'(phase_o), 32'h0000_0077);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (sp_o != '0 || pos_o != '0) bad++;
    end
    check("idle_no_step", 32'(bad), 32'd0);

    // Position wrap (or soft limit) at the top of the 8-bit range
    per_s = 17'd2; dir_s = 4'b0001; hs_s = 2'b01;
    found = 0;
    cyc = 0;
    while (!found && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (m_pos[0] == 8'sd127) found = 1;
    end
    check("reach_127", 32'(found), 32'd1);
    check("pre_wrap_pos", 32'(pos_o[7:0]), 32'h7F);
`ifndef STEPPER_LIMIT_EN
    wait_pulse("wrap_pulse", 10);
    check("wrap_pos", 32'(pos_o[7:0]), 32'h80);
`else
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (sp_o[0]) bad++;
    end
    check("limit_no_pulse", 32'(bad), 32'd0);
    check("limit_pos", 32'(pos_o[7:0]), 32'h7F);
    check("limit_hit_set", 32'(lh_o[0]), 32'd1);
    dir_s = 4'b0010;
    wait_pulse("limit_rev_pulse", 10);
    check("limit_rev_pos", 32'(pos_o[7:0]), 32'h7E);
    check("limit_hit_clr", 32'(lh_o[0]), 32'd0);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
